// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the paralelo_serial_tx TX lane: symbol defaults, FSM encoding
// and bit-counter sizing.
package paralelo_serial_tx_pkg;

   localparam logic [7:0] COM_SYM_DEF = 8'hBC;
   localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

   localparam int unsigned BIT_CNT_W = 3;
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 3'd7;

   typedef enum logic {
      TRAIN  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/paralelo_serial_tx_shifter.sv
// 8-bit MSB-first symbol shifter. The cycle with bit_cnt == 7 is the symbol boundary,
// where next_sym is loaded instead of shifting.
module paralelo_serial_tx_shifter
   import paralelo_serial_tx_pkg::*;
(
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] next_sym,
   output logic       serial_bit,
   output logic       boundary
);

   logic [7:0]           shift_reg;
   logic [BIT_CNT_W-1:0] bit_cnt;

   assign boundary   = (bit_cnt == BIT_CNT_LAST);
   assign serial_bit = shift_reg[7];

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the bit counter resets to 7 so edge 1 is already a boundary.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         shift_reg <= 8'h00;
         bit_cnt   <= BIT_CNT_LAST;
      end else if (boundary) begin
         shift_reg <= next_sym;
         bit_cnt   <= '0;
      end else begin
         shift_reg <= {shift_reg[6:0], 1'b0};
         bit_cnt   <= bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: TX parallel-to-serial stage with COM training burst, IDL fill and a
// one-entry valid/ready hold register. Define PS_TX_COUNT_EN to add the tx_count output.
module paralelo_serial_tx
   import paralelo_serial_tx_pkg::*;
#(
   parameter int unsigned COM_COUNT = 4,
   parameter logic [7:0]  COM_SYM   = COM_SYM_DEF,
   parameter logic [7:0]  IDL_SYM   = IDL_SYM_DEF
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [7:0]  data_in,
   output logic        ready_out,
   output logic        data_out,
   output logic        active_out
`ifdef PS_TX_COUNT_EN
   ,
   output logic [15:0] tx_count
`endif
);

   localparam logic [3:0] COM_LAST = COM_COUNT[3:0];

   state_t     state;
   state_t     state_nxt;
   logic [3:0] com_cnt;
   logic       com_inc;
   logic       hold_valid;
   logic [7:0] hold_data;
   logic [7:0] next_sym;
   logic       boundary;
   logic       drain;
   logic       accept;

   paralelo_serial_tx_shifter u_shifter (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .next_sym   (next_sym),
      .serial_bit (data_out),
      .boundary   (boundary)
   );

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      next_sym  = IDL_SYM;
      drain     = 1'b0;
      com_inc   = 1'b0;
      unique case (state)
         TRAIN: begin
            if (com_cnt == COM_LAST) begin
               next_sym = hold_valid ? hold_data : IDL_SYM;
               drain    = boundary && hold_valid;
               if (boundary) state_nxt = ACTIVE;
            end else begin
               next_sym = COM_SYM;
               com_inc  = boundary;
            end
         end
         ACTIVE: begin
            next_sym = hold_valid ? hold_data : IDL_SYM;
            drain    = boundary && hold_valid;
         end
         default: state_nxt = TRAIN;
      endcase
   end

   // Drain-through: a full hold can still accept on the ACTIVE boundary that empties it.
   assign ready_out  = !hold_valid || ((state == ACTIVE) && drain);
   assign accept     = valid_in && ready_out;
   assign active_out = (state == ACTIVE);

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state      <= TRAIN;
         com_cnt    <= 4'd0;
         hold_valid <= 1'b0;
         hold_data  <= 8'h00;
      end else begin
         state <= state_nxt;
         if (com_inc) com_cnt <= com_cnt + 1'b1;
         if (accept) begin
            hold_data  <= data_in;
            hold_valid <= 1'b1;
         end else if (drain) begin
            hold_valid <= 1'b0;
         end
      end
   end

`ifdef PS_TX_COUNT_EN
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset)      tx_count <= 16'h0000;
      else if (drain) tx_count <= tx_count + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx against a slot-level model of the serial stream.
// Checks tx_count as well when PS_TX_COUNT_EN is defined.
module tb_paralelo_serial_tx;

   localparam int         COM_COUNT = 4;
   localparam logic [7:0] COM_SYM   = 8'hBC;
   localparam logic [7:0] IDL_SYM   = 8'h7C;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic       valid_in = 1'b0;
   logic [7:0] data_in  = 8'h00;
   logic       ready_out;
   logic       data_out;
   logic       active_out;
`ifdef PS_TX_COUNT_EN
   logic [15:0] tx_count;
`endif

   paralelo_serial_tx #(
      .COM_COUNT (COM_COUNT),
      .COM_SYM   (COM_SYM),
      .IDL_SYM   (IDL_SYM)
   ) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .active_out (active_out)
`ifdef PS_TX_COUNT_EN
      ,
      .tx_count   (tx_count)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   int vectors = 0;
   int errors  = 0;

   // Model: n = edges since reset; slot k = (n-1)/8; slots below COM_COUNT are COMs, later
   // slots carry the pending byte if one is waiting at the slot start, else IDL.
   int          m_n;
   logic        m_pending;
   logic [7:0]  m_pbyte;
   logic [7:0]  m_cur;
   logic        m_cur_data;
   logic [15:0] m_tx;
   logic        last_acc;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d got=%h exp=%h", tag, m_n, got, exp);
      end
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255)); while (b == COM_SYM || b == IDL_SYM);
      return b;
   endfunction

   function automatic logic model_ready();
      logic next_is_start = (m_n % 8) == 0;
      logic active_now    = m_n >= 8 * COM_COUNT + 1;
      return !m_pending || (next_is_start && active_now);
   endfunction

   task automatic check_outputs();
      int   pos = (m_n - 1) % 8;
      logic exp_bit = (m_n == 0) ? 1'b0 : m_cur[3'(7 - pos)];
      check("data_out", {15'd0, data_out}, {15'd0, exp_bit});
      check("active_out", {15'd0, active_out}, {15'd0, (m_n >= 8 * COM_COUNT + 1)});
`ifdef PS_TX_COUNT_EN
      check("tx_count", tx_count, m_tx);
`endif
   endtask

   task automatic model_reset();
      m_n = 0; m_pending = 1'b0; m_pbyte = 8'h00;
      m_cur = 8'h00; m_cur_data = 1'b0; m_tx = 16'h0000;
   endtask

   // Entered at posedge+1 or later; returns at posedge+1.
   task automatic step(input logic v, input logic [7:0] d);
      logic acc;
      int   k;
      valid_in = v;
      data_in  = d;
      #1;
      check("ready_out", {15'd0, ready_out}, {15'd0, model_ready()});
      acc = v && model_ready();
      @(posedge clk_32f);
      #1;
      m_n++;
      if ((m_n - 1) % 8 == 0) begin
         k = (m_n - 1) / 8;
         m_cur_data = 1'b0;
         if (k < COM_COUNT) m_cur = COM_SYM;
         else if (m_pending) begin
            m_cur = m_pbyte; m_pending = 1'b0; m_cur_data = 1'b1; m_tx++;
         end else m_cur = IDL_SYM;
      end
      if (acc) begin
         m_pending = 1'b1;
         m_pbyte   = d;
      end
      last_acc = acc;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid_in = 1'b0;
      model_reset();
      #1;
      check("rst_data_out", {15'd0, data_out}, 16'd0);
      check("rst_active_out", {15'd0, active_out}, 16'd0);
      check("rst_ready_out", {15'd0, ready_out}, 16'd1);
      @(posedge clk_32f);
      #2 reset = 1'b0;
      #1 check_outputs();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 8'h00);
   endtask

   task automatic send_queue(input logic [7:0] bytes[$]);
      int budget = 200;
      while (bytes.size() > 0 && budget > 0) begin
         step(1'b1, bytes[0]);
         if (last_acc) void'(bytes.pop_front());
         budget--;
      end
      check("send_budget", 16'(bytes.size()), 16'd0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic       found;

      model_reset();
      last_acc = 1'b0;

      // Training burst with no traffic, then IDL fill.
      do_reset();
      idle(8 * COM_COUNT + 16);

      // Byte offered on the first cycle after reset is held through training.
      do_reset();
      step(1'b1, 8'hA5);
      check("a5_accepted", {15'd0, last_acc}, 16'd1);
      idle(8 * COM_COUNT + 16);

      // Back-to-back bytes with valid held.
      q = '{8'h12, 8'h34, 8'h56};
      send_queue(q);
      idle(24);

      // Byte offered mid-IDL at a random phase.
      idle($urandom_range(1, 7));
      step(1'b1, rand_byte());
      idle(16);

      // Random traffic.
      for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), rand_byte());

      // Async reset at bit 3 of a data byte while the hold is full.
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step(1'b1, rand_byte());
         found = m_cur_data && ((m_n - 1) % 8 == 3) && m_pending;
      end
      check("reset_point_found", {15'd0, found}, 16'd1);
      #2 do_reset();
      idle(8 * COM_COUNT + 16);

      // Data interleaved with IDL, then reset clears any counter.
      for (int i = 0; i < 3; i++) begin
         q = '{rand_byte()};
         send_queue(q);
         idle(12);
      end
      do_reset();
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule
